// File: rtl/div_iter.sv
// div_iter - iterative radix-2 restoring integer divider.
//
// Produces quotient and remainder, one quotient bit per clock, with RISC-V
// DIV/DIVU/REM/REMU semantics (x/0 -> all ones, remainder = x; min/-1 -> min, 0).
// The flow is IDLE -> CALC (WIDTH cycles) -> DONE -> IDLE.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_valid / in_ready    request handshake (in_ready only in IDLE)
//   in_signed              1 = signed operation, sampled at the handshake
//   dividend, divisor      operands
//   flush                  abort any in-flight or pending operation
//   out_valid / out_ready  result handshake (results held while out_valid)
//   quotient, remainder    results
//   div_by_zero            result came from a zero divisor
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    state_t           state_r;
    logic [WIDTH-1:0] rem_r;        // partial remainder
    logic [WIDTH-1:0] quo_r;        // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dvs_r;        // divisor magnitude
    logic [CW-1:0]    cnt_r;        // step counter, 0 .. WIDTH-1
    logic             neg_q_r;
    logic             neg_rem_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             dbz_r;

    logic             a_neg_s;
    logic             b_neg_s;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] quo_next_s;
    logic [WIDTH-1:0] q_final_s;
    logic [WIDTH-1:0] r_final_s;

    // Acceptance depends only on state and reset, never on in_valid/out_ready.
    assign in_ready    = (state_r == IDLE) && !rst;
    assign out_valid   = out_valid_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;

    // Operand magnitudes; min-int negates to itself, read back as 2^(WIDTH-1) unsigned.
    always_comb begin
        a_neg_s = in_signed & dividend[WIDTH-1];
        b_neg_s = in_signed & divisor[WIDTH-1];
        if (a_neg_s) begin
            a_mag_s = -dividend;
        end else begin
            a_mag_s = dividend;
        end
        if (b_neg_s) begin
            b_mag_s = -divisor;
        end else begin
            b_mag_s = divisor;
        end
    end

    // One restoring step: shift in the next dividend bit, trial subtract at WIDTH+1 bits.
    always_comb begin
        shifted_s = {rem_r, quo_r[WIDTH-1]};
        trial_s   = shifted_s - {1'b0, dvs_r};
        if (trial_s[WIDTH] == 1'b0) begin
            rem_next_s = trial_s[WIDTH-1:0];
            quo_next_s = {quo_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_next_s = shifted_s[WIDTH-1:0];
            quo_next_s = {quo_r[WIDTH-2:0], 1'b0};
        end
        if (neg_q_r) begin
            q_final_s = -quo_next_s;
        end else begin
            q_final_s = quo_next_s;
        end
        if (neg_rem_r) begin
            r_final_s = -rem_next_s;
        end else begin
            r_final_s = rem_next_s;
        end
    end

    // Control FSM with datapath and registered results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            rem_r       <= {WIDTH{1'b0}};
            quo_r       <= {WIDTH{1'b0}};
            dvs_r       <= {WIDTH{1'b0}};
            cnt_r       <= {CW{1'b0}};
            neg_q_r     <= 1'b0;
            neg_rem_r   <= 1'b0;
            out_valid_r <= 1'b0;
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            dbz_r       <= 1'b0;
        end else if (flush) begin
            // Result registers intentionally keep their last value.
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        if (divisor == {WIDTH{1'b0}}) begin
                            quotient_r  <= {WIDTH{1'b1}};
                            remainder_r <= dividend;
                            dbz_r       <= 1'b1;
                            out_valid_r <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            rem_r     <= {WIDTH{1'b0}};
                            quo_r     <= a_mag_s;
                            dvs_r     <= b_mag_s;
                            cnt_r     <= {CW{1'b0}};
                            neg_q_r   <= a_neg_s ^ b_neg_s;
                            neg_rem_r <= a_neg_s;
                            state_r   <= CALC;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    rem_r <= rem_next_s;
                    quo_r <= quo_next_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == LAST_STEP) begin
                        quotient_r  <= q_final_s;
                        remainder_r <= r_final_s;
                        dbz_r       <= 1'b0;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        state_r <= CALC;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter - self-checking bench for div_iter (WIDTH=32).
// A behavioural model (64-bit integer arithmetic) predicts every result; a
// compare process checks the DUT outputs on every cycle out_valid is high.
module tb_div_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         in_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    logic         exp_active = 1'b0;
    logic [W-1:0] exp_q;
    logic [W-1:0] exp_r;
    logic         exp_dz;

    div_iter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_signed(in_signed), .dividend(dividend), .divisor(divisor),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: RISC-V division rules with wide signed integers.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                    output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
        longint la, lb, lq, lr;
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            dz = 1'b1;
        end else begin
            if (s) begin
                la = longint'($signed(a));
                lb = longint'($signed(b));
            end else begin
                la = longint'({32'd0, a});
                lb = longint'({32'd0, b});
            end
            lq = la / lb;
            lr = la % lb;
            q  = lq[W-1:0];
            r  = lr[W-1:0];
            dz = 1'b0;
        end
    endfunction

    // Compare process: whenever a result is presented it must match the model.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            check("unexpected_out_valid", {63'd0, exp_active}, 64'd1);
            if (exp_active) begin
                check("quotient", {32'd0, quotient}, {32'd0, exp_q});
                check("remainder", {32'd0, remainder}, {32'd0, exp_r});
                check("div_by_zero", {63'd0, div_by_zero}, {63'd0, exp_dz});
                check("in_ready_in_done", {63'd0, in_ready}, 64'd0);
            end
        end
    end

    // Present one request, then wait for the result; lat counts edges including the accept edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, output int lat);
        @(negedge clk);
        check("in_ready_idle", {63'd0, in_ready}, 64'd1);
        dividend  = a;
        divisor   = b;
        in_signed = s;
        in_valid  = 1'b1;
        ref_div(a, b, s, exp_q, exp_r, exp_dz);
        @(posedge clk);
        #1;
        exp_active = 1'b1;
        in_valid   = 1'b0;
        dividend   = $urandom;
        divisor    = $urandom;
        in_signed  = 1'($urandom_range(0, 1));
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) begin
            check("result_timeout", 64'd0, 64'd1);
        end
    endtask

    // Hold off the consumer for `stall` cycles, then accept the result.
    task automatic retire(input int stall);
        repeat (stall) begin
            @(negedge clk);
            check("in_ready_stall", {63'd0, in_ready}, 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_active = 1'b0;
        out_ready  = 1'b0;
        check("out_valid_drop", {63'd0, out_valid}, 64'd0);
        check("in_ready_after", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input int stall, input int req_lat,
                          input logic [W-1:0] req_q, input logic [W-1:0] req_r);
        int lat;
        issue(a, b, s, lat);
        check("latency", 64'(lat), 64'(req_lat));
        check("literal_q", {32'd0, quotient}, {32'd0, req_q});
        check("literal_r", {32'd0, remainder}, {32'd0, req_r});
        retire(stall);
    endtask

    // Start an op, abort it at CALC step 5 with flush or reset, and check no result emerges.
    task automatic abort_test(input logic use_rst);
        @(negedge clk);
        dividend  = 32'd1000;
        divisor   = 32'd3;
        in_signed = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        if (use_rst) begin
            rst = 1'b1;
            #1;
            check("rst_in_ready_low", {63'd0, in_ready}, 64'd0);
            @(negedge clk);
            rst = 1'b0;
        end else begin
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
        end
        @(posedge clk);
        #1;
        check("abort_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_result", {63'd0, out_valid}, 64'd0);
    endtask

    logic [W-1:0] mq, mr;
    logic         mdz;
    int           lat0;

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 20));
            6:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_signed = 1'b0;
        dividend  = 32'd0;
        divisor   = 32'd0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Pin the model with hand-computed values.
        ref_div(32'd100, 32'd7, 1'b0, mq, mr, mdz);
        check("model_100_7_q", {32'd0, mq}, 64'd14);
        check("model_100_7_r", {32'd0, mr}, 64'd2);
        ref_div(-32'd7, 32'd2, 1'b1, mq, mr, mdz);
        check("model_m7_2", {mq, mr}, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
        ref_div(32'd7, -32'd2, 1'b1, mq, mr, mdz);
        check("model_7_m2", {mq, mr}, {32'hFFFF_FFFD, 32'd1});
        ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, mq, mr, mdz);
        check("model_ovf", {mq, mr}, {32'h8000_0000, 32'd0});
        ref_div(32'h1234, 32'd0, 1'b1, mq, mr, mdz);
        check("model_dz", {mq, mr}, {32'hFFFF_FFFF, 32'h1234});
        check("model_dz_flag", {63'd0, mdz}, 64'd1);

        // Reset state.
        #2;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_results", {quotient, remainder}, 64'd0);
        check("rst_dz", {63'd0, div_by_zero}, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        run_op(32'd100, 32'd7, 1'b0, 0, 33, 32'd14, 32'd2);
        run_op(-32'd7, 32'd2, 1'b1, 0, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_op(32'd7, -32'd2, 1'b1, 1, 33, 32'hFFFF_FFFD, 32'd1);
        run_op(32'h1234, 32'd0, 1'b0, 0, 1, 32'hFFFF_FFFF, 32'h1234);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 33, 32'h8000_0000, 32'd0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 33, 32'd0, 32'h8000_0000);
        // Long consumer stall, then an immediate follow-on op.
        run_op(32'd1000, 32'd10, 1'b0, 10, 33, 32'd100, 32'd0);
        run_op(32'd55, 32'd5, 1'b0, 0, 33, 32'd11, 32'd0);

        // Flush and reset mid-CALC, each followed by 9/3.
        abort_test(1'b0);
        run_op(32'd9, 32'd3, 1'b0, 0, 33, 32'd3, 32'd0);
        abort_test(1'b1);
        run_op(32'd9, 32'd3, 1'b0, 0, 33, 32'd3, 32'd0);

        // Flush in DONE together with out_ready discards the result but keeps result registers.
        issue(32'd50, 32'd4, 1'b0, lat0);
        @(negedge clk);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_active = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        check("flush_done_valid", {63'd0, out_valid}, 64'd0);
        check("flush_done_keep_q", {32'd0, quotient}, 64'd12);
        check("flush_done_in_ready", {63'd0, in_ready}, 64'd1);

        // Randomized operands with corner values mixed in.
        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] a, b;
            logic         s;
            a = pick();
            b = pick();
            s = 1'($urandom_range(0, 1));
            issue(a, b, s, lat0);
            check("rand_latency", 64'(lat0), (b == 32'd0) ? 64'd1 : 64'd33);
            retire($urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
